// File: rtl/pipeline_hazard_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_sequencer
//
// Central stall and sequencing controller for the 5-stage pipeline. Produces
// the bubble request (st) for the main control decoder and the write enables
// for PC and the four pipeline registers. It handles three situations:
//   - a post-reset hold of RESET_HOLD cycles,
//   - load-use hazards detected in ID (one bubble is inserted),
//   - a full freeze while the data memory handshake is pending.
// A memory access that never completes moves the sequencer into a terminal
// error state. Only reset leaves that state.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   id_opcode   opcode of the instruction in ID
//   id_rs       first source register of the ID instruction
//   id_rt       second source register of the ID instruction
//   ex_memread  MemRead held in ID/EX
//   ex_rd       destination register held in ID/EX
//   mem_req     EX/MEM holds a load or store
//   dmem_ack    data memory completes the access this cycle
//   st          bubble request to the control decoder
//   pc_we       PC write enable
//   ifid_we     IF/ID write enable
//   idex_we     ID/EX write enable
//   exmem_we    EX/MEM write enable
//   memwb_we    MEM/WB write enable
//   mem_err     sticky data-memory timeout flag
//   stall_cnt   saturating count of stalled cycles in RUN/MEM_WAIT
// -----------------------------------------------------------------------------
module pipeline_hazard_sequencer #(
   parameter int REG_AW      = 4,
   parameter int RESET_HOLD  = 2,
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        id_opcode,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              ex_memread,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              mem_req,
   input  logic              dmem_ack,
   output logic              st,
   output logic              pc_we,
   output logic              ifid_we,
   output logic              idex_we,
   output logic              exmem_we,
   output logic              memwb_we,
   output logic              mem_err,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      S_HOLD     = 2'd0,
      S_RUN      = 2'd1,
      S_MEM_WAIT = 2'd2,
      S_ERR      = 2'd3
   } state_e;

   // Terminal values of the hold and wait counters. Each transition happens
   // on the edge where its counter reaches the terminal value.
   localparam logic [3:0]  HOLD_LAST = 4'(RESET_HOLD - 1);
   localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e           state_q, state_d;
   logic [3:0]       hold_cnt_q, hold_cnt_d;
   logic [15:0]      wait_cnt_q, wait_cnt_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic uses_rt;
   logic lu;
   logic mw;

   // Only the R-type ALU ops read rt as a source. nandi, lw and any
   // undefined opcode use rt as a destination or not at all.
   always_comb begin
      case (id_opcode)
         4'b0000, 4'b0011, 4'b1111: uses_rt = 1'b1;
         default:                   uses_rt = 1'b0;
      endcase
   end

   // Register 0 gets no exemption. When rs and rt name the same register,
   // both terms match but the result is still a single stall request.
   assign lu = ex_memread & ((id_rs == ex_rd) | (uses_rt & (id_rt == ex_rd)));
   assign mw = mem_req & ~dmem_ack;

   // NOTE: every signal written in this block gets a default first, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      st          = 1'b0;
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      memwb_we    = 1'b0;

      case (state_q)
         S_HOLD: begin
            st         = 1'b1;
            hold_cnt_d = hold_cnt_q + 4'd1;
            if (hold_cnt_q == HOLD_LAST) begin
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            if (mw) begin
               // A pending memory access freezes everything. No bubble is
               // needed because nothing advances.
               state_d    = S_MEM_WAIT;
               wait_cnt_d = 16'd1;
            end else if (lu) begin
               // Hold PC and IF/ID and push a bubble into ID/EX. The
               // downstream stages keep draining.
               st       = 1'b1;
               idex_we  = 1'b1;
               exmem_we = 1'b1;
               memwb_we = 1'b1;
            end else begin
               pc_we    = 1'b1;
               ifid_we  = 1'b1;
               idex_we  = 1'b1;
               exmem_we = 1'b1;
               memwb_we = 1'b1;
            end
         end

         S_MEM_WAIT: begin
            if (dmem_ack) begin
               // The pipeline was frozen, so a load-use hazard that was
               // present may still be present. Resolve it on the release
               // cycle.
               st         = lu;
               pc_we      = ~lu;
               ifid_we    = ~lu;
               idex_we    = 1'b1;
               exmem_we   = 1'b1;
               memwb_we   = 1'b1;
               state_d    = S_RUN;
               wait_cnt_d = 16'd0;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d = S_ERR;
            end else begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end

         S_ERR: begin
            st = 1'b1;
         end

         default: begin
            state_d = S_HOLD;
         end
      endcase

      mem_err_d = mem_err_q | (state_d == S_ERR);

      stall_cnt_d = stall_cnt_q;
      if (((state_q == S_RUN) || (state_q == S_MEM_WAIT)) && !pc_we &&
          (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments so that
   // every register samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_HOLD;
         hold_cnt_q  <= 4'd0;
         wait_cnt_q  <= 16'd0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign mem_err   = mem_err_q;
   assign stall_cnt = stall_cnt_q;

endmodule
